// File: rtl/regfile_access_arbiter_pkg.sv
// Shared constants and types for the register-file access arbiter.
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 16;
   localparam int DEFAULT_INDEX_WIDTH = 2;
   localparam int NUM_REGS            = 2 ** DEFAULT_INDEX_WIDTH;
   localparam int NUM_REQ             = 2;

   typedef enum logic {
      ARB_INIT,
      ARB_RUN
   } arb_state_t;

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Request/response bus between the two requesters and the arbiter.
// Per-requester fields are packed side by side, requester i at slice i.
interface regfile_access_arbiter_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             req_write;
   logic [NUM_REQ*INDEX_WIDTH-1:0] req_index;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [NUM_REQ-1:0]             rsp_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata;

   modport master (
      output req_valid, req_write, req_index, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_index, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/regfile_access_arbiter_rr.sv
// Two-way round-robin grant: a lone eligible requester wins outright,
// a tie goes to rr_ptr, and the loser of each grant gets priority next.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   logic rr_ptr;

   // One-hot grant from the eligible set, tie broken by rr_ptr
   always_comb begin
      grant = elig;
      if (elig == 2'b11) begin
         grant = rr_ptr ? 2'b10 : 2'b01;
      end
   end

   // Hand priority to the requester that was not just served
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= 1'b0;
      end else if (grant != 2'b00) begin
         rr_ptr <= grant[0];
      end
   end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a 1R/1W register file between two requesters. After reset an
// optional init pass fills every register, then round-robin arbitration
// serves posted writes and registered read responses.
module regfile_access_arbiter
   import regfile_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int                    INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int                    INIT_EN     = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_access_arbiter_if.slave bus,
   output logic [INDEX_WIDTH-1:0] rf_read_index,
   input  logic [DATA_WIDTH-1:0]  rf_read_data,
   output logic [INDEX_WIDTH-1:0] rf_write_index,
   output logic                   rf_write_enable,
   output logic [DATA_WIDTH-1:0]  rf_write_data,
   output logic                   init_done
);

   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

   arb_state_t                    state;
   arb_state_t                    state_next;
   logic [INDEX_WIDTH-1:0]        init_cnt;
   logic [NUM_REQ-1:0]            elig;
   logic [NUM_REQ-1:0]            grant;
   logic                          sel_write;
   logic [INDEX_WIDTH-1:0]        sel_index;
   logic [DATA_WIDTH-1:0]         sel_wdata;
   logic [NUM_REQ-1:0]            rsp_valid_q;
   logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata_q;

   // A read may only be granted if its response slot is free or draining now
   always_comb begin
      elig = '0;
      if (reset && state == ARB_RUN) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] &&
                      (bus.req_write[i] || !rsp_valid_q[i] || bus.rsp_ready[i]);
         end
      end
   end

   rr_arbiter2 u_rr (
      .clk   (clk),
      .reset (reset),
      .elig  (elig),
      .grant (grant)
   );

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   assign sel_write = grant[1] ? bus.req_write[1] : bus.req_write[0];
   assign sel_index = grant[1] ? bus.req_index[INDEX_WIDTH +: INDEX_WIDTH]
                               : bus.req_index[0 +: INDEX_WIDTH];
   assign sel_wdata = grant[1] ? bus.req_wdata[DATA_WIDTH +: DATA_WIDTH]
                               : bus.req_wdata[0 +: DATA_WIDTH];

   // Next state and register-file port mux; everything idles to 0 in reset
   always_comb begin
      state_next      = state;
      rf_write_enable = 1'b0;
      rf_write_index  = '0;
      rf_write_data   = '0;
      rf_read_index   = '0;
      if (state == ARB_INIT && (INIT_EN == 0 || init_cnt == LAST_INDEX)) begin
         state_next = ARB_RUN;
      end
      if (reset) begin
         if (state == ARB_INIT) begin
            if (INIT_EN != 0) begin
               rf_write_enable = 1'b1;
               rf_write_index  = init_cnt;
               rf_write_data   = INIT_VALUE;
            end
         end else if (grant != '0) begin
            if (sel_write) begin
               rf_write_enable = 1'b1;
               rf_write_index  = sel_index;
               rf_write_data   = sel_wdata;
            end else begin
               rf_read_index = sel_index;
            end
         end
      end
   end

   // State register, init counter and the registered init_done flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARB_INIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_next;
         init_done <= (state_next == ARB_RUN);
         if (state == ARB_INIT) begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // Capture read data on grant; otherwise drop valid once it is consumed
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && !bus.req_write[i]) begin
               rsp_valid_q[i]                          <= 1'b1;
               rsp_rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= rf_read_data;
            end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
               rsp_valid_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed scenarios plus a random run,
// all checked against a transaction-level model of the arbiter.
module tb_regfile_access_arbiter;
   import regfile_pkg::*;

   localparam int          DW       = 16;
   localparam int          IW       = 2;
   localparam int          NR       = 4;
   localparam logic [15:0] INIT_VAL = 16'hA5A5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [IW-1:0] rf_read_index;
   logic [DW-1:0] rf_read_data;
   logic [IW-1:0] rf_write_index;
   logic          rf_write_enable;
   logic [DW-1:0] rf_write_data;
   logic          init_done;
   logic [DW-1:0] rf_mem [NR];

   int checks   = 0;
   int failures = 0;

   regfile_access_arbiter_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

   regfile_access_arbiter #(
      .DATA_WIDTH (DW),
      .INDEX_WIDTH(IW),
      .INIT_EN    (1),
      .INIT_VALUE (INIT_VAL)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .rf_read_index  (rf_read_index),
      .rf_read_data   (rf_read_data),
      .rf_write_index (rf_write_index),
      .rf_write_enable(rf_write_enable),
      .rf_write_data  (rf_write_data),
      .init_done      (init_done)
   );

   always #5 clk = ~clk;

   // Register file stub: combinational read, write at the rising edge
   assign rf_read_data = rf_mem[rf_read_index];
   always @(posedge clk) begin
      if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;
   end

   // Reference model state
   logic [DW-1:0] m_mem [NR];
   logic [1:0]    m_rsp_valid;
   logic [DW-1:0] m_rsp_data [2];
   int            m_rr;
   int            m_init_cnt;
   bit            m_run;

   function automatic logic [IW-1:0] idx_of(int i);
      return bus.req_index[i*IW +: IW];
   endfunction

   function automatic logic [DW-1:0] wd_of(int i);
      return bus.req_wdata[i*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rd_of(int i);
      return bus.rsp_rdata[i*DW +: DW];
   endfunction

   function automatic logic [1:0] exp_grant();
      logic [1:0] e;
      e = 2'b00;
      if (!m_run || reset !== 1'b1) return 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (bus.req_valid[i] && (bus.req_write[i] || !m_rsp_valid[i] || bus.rsp_ready[i]))
            e[i] = 1'b1;
      end
      if (e == 2'b11) e = (m_rr == 0) ? 2'b01 : 2'b10;
      return e;
   endfunction

   task automatic model_reset();
      m_rsp_valid   = 2'b00;
      m_rsp_data[0] = '0;
      m_rsp_data[1] = '0;
      m_rr          = 0;
      m_init_cnt    = 0;
      m_run         = 1'b0;
   endtask

   // Advance one clock, applying the arbiter rules to the model at the edge
   task automatic tick();
      logic [1:0] g;
      g = exp_grant();
      @(posedge clk);
      if (reset === 1'b1) begin
         if (!m_run) begin
            m_mem[m_init_cnt] = INIT_VAL;
            m_init_cnt++;
            if (m_init_cnt == NR) m_run = 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (g[i] && !bus.req_write[i]) begin
                  m_rsp_valid[i] = 1'b1;
                  m_rsp_data[i]  = m_mem[idx_of(i)];
               end else if (m_rsp_valid[i] && bus.rsp_ready[i]) begin
                  m_rsp_valid[i] = 1'b0;
               end
               if (g[i] && bus.req_write[i]) m_mem[idx_of(i)] = wd_of(i);
            end
            if (g != 2'b00) m_rr = g[0] ? 1 : 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_req(int i, bit v, bit w, logic [IW-1:0] idx, logic [DW-1:0] d);
      bus.req_valid[i]          = v;
      bus.req_write[i]          = w;
      bus.req_index[i*IW +: IW] = idx;
      bus.req_wdata[i*DW +: DW] = d;
   endtask

   task automatic idle();
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_index = '0;
      bus.req_wdata = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      idle();
      bus.rsp_ready = 2'b11;
      bus.req_valid = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
      checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%b exp=0", rf_write_enable); end
      checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== '0) begin failures++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_init_done got=%b exp=0", init_done); end
   endtask

   task automatic test_init();
      idle();
      bus.req_valid = 2'b11;
      reset = 1'b1;
      for (int k = 0; k < NR; k++) begin
         #1;
         checks++;
         if (rf_write_enable !== 1'b1 || rf_write_index !== IW'(k) || rf_write_data !== INIT_VAL) begin
            failures++;
            $display("[TB] FAIL init_write[%0d] got we=%b idx=%0d data=%h exp we=1 idx=%0d data=%h",
                     k, rf_write_enable, rf_write_index, rf_write_data, k, INIT_VAL);
         end
         checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("[TB] FAIL init_req_ready[%0d] got=%b exp=00", k, bus.req_ready); end
         checks++; if (init_done !== 1'b0) begin failures++; $display("[TB] FAIL init_done_early[%0d] got=%b exp=0", k, init_done); end
         tick();
      end
      idle();
      #1;
      checks++; if (init_done !== 1'b1) begin failures++; $display("[TB] FAIL init_done got=%b exp=1", init_done); end
   endtask

   task automatic test_read_after_init();
      idle();
      bus.rsp_ready = 2'b11;
      set_req(0, 1'b1, 1'b0, 2'd2, '0);
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("[TB] FAIL first_read_grant got=%b exp=01", bus.req_ready); end
      checks++; if (rf_read_index !== 2'd2) begin failures++; $display("[TB] FAIL first_read_index got=%0d exp=2", rf_read_index); end
      tick();
      checks++; if (bus.rsp_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL first_read_valid got=%b exp=1", bus.rsp_valid[0]); end
      checks++; if (rd_of(0) !== 16'hA5A5) begin failures++; $display("[TB] FAIL first_read_data got=%h exp=a5a5", rd_of(0)); end
   endtask

   task automatic test_write_then_read();
      idle();
      set_req(0, 1'b1, 1'b1, 2'd1, 16'h1234);
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("[TB] FAIL wr_grant got=%b exp=01", bus.req_ready); end
      checks++;
      if (rf_write_enable !== 1'b1 || rf_write_index !== 2'd1 || rf_write_data !== 16'h1234) begin
         failures++;
         $display("[TB] FAIL wr_port got we=%b idx=%0d data=%h exp we=1 idx=1 data=1234", rf_write_enable, rf_write_index, rf_write_data);
      end
      tick();
      idle();
      set_req(1, 1'b1, 1'b0, 2'd1, '0);
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("[TB] FAIL rd1_grant got=%b exp=10", bus.req_ready); end
      tick();
      checks++; if (bus.rsp_valid[1] !== 1'b1) begin failures++; $display("[TB] FAIL rd1_valid got=%b exp=1", bus.rsp_valid[1]); end
      checks++; if (rd_of(1) !== 16'h1234) begin failures++; $display("[TB] FAIL rd1_data got=%h exp=1234", rd_of(1)); end
      idle();
      tick();
   endtask

   task automatic test_alternating();
      logic [1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
      reset = 1'b0;
      model_reset();
      idle();
      bus.rsp_ready = 2'b11;
      set_req(0, 1'b1, 1'b0, 2'd0, '0);
      set_req(1, 1'b1, 1'b0, 2'd3, '0);
      @(negedge clk);
      reset = 1'b1;
      repeat (NR) tick();
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.req_ready !== seq[k]) begin failures++; $display("[TB] FAIL alt_grant[%0d] got=%b exp=%b", k, bus.req_ready, seq[k]); end
         tick();
         checks++; if (bus.rsp_valid !== seq[k]) begin failures++; $display("[TB] FAIL alt_rsp_valid[%0d] got=%b exp=%b", k, bus.rsp_valid, seq[k]); end
         checks++; if (rd_of(k % 2) !== m_rsp_data[k % 2]) begin failures++; $display("[TB] FAIL alt_data[%0d] got=%h exp=%h", k, rd_of(k % 2), m_rsp_data[k % 2]); end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      idle();
      bus.rsp_ready = 2'b11;
      set_req(0, 1'b1, 1'b1, 2'd0, 16'h0F0F);
      tick();
      idle();
      set_req(0, 1'b1, 1'b0, 2'd3, '0);
      bus.rsp_ready = 2'b10;
      tick();
      held = rd_of(0);
      checks++; if (bus.rsp_valid[0] !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid0 got=%b exp=1", bus.rsp_valid[0]); end
      checks++; if (held !== INIT_VAL) begin failures++; $display("[TB] FAIL bp_data0 got=%h exp=%h", held, INIT_VAL); end
      set_req(0, 1'b1, 1'b0, 2'd0, '0);
      set_req(1, 1'b1, 1'b0, 2'd2, '0);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("[TB] FAIL bp_grant[%0d] got=%b exp=10", k, bus.req_ready); end
         tick();
         checks++;
         if (bus.rsp_valid !== 2'b11 || rd_of(0) !== held) begin
            failures++;
            $display("[TB] FAIL bp_hold[%0d] got valid=%b data0=%h exp valid=11 data0=%h", k, bus.rsp_valid, rd_of(0), held);
         end
      end
      bus.rsp_ready = 2'b11;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("[TB] FAIL bp_release_grant got=%b exp=01", bus.req_ready); end
      tick();
      checks++;
      if (bus.rsp_valid[0] !== 1'b1 || rd_of(0) !== 16'h0F0F) begin
         failures++;
         $display("[TB] FAIL bp_release_data got valid=%b data=%h exp valid=1 data=0f0f", bus.rsp_valid[0], rd_of(0));
      end
   endtask

   task automatic test_write_while_stalled();
      idle();
      bus.rsp_ready = 2'b10;
      set_req(0, 1'b1, 1'b1, 2'd3, 16'hBEEF);
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("[TB] FAIL stall_wr_grant got=%b exp=01", bus.req_ready); end
      checks++;
      if (rf_write_enable !== 1'b1 || rf_write_index !== 2'd3 || rf_write_data !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL stall_wr_port got we=%b idx=%0d data=%h exp we=1 idx=3 data=beef", rf_write_enable, rf_write_index, rf_write_data);
      end
      tick();
      checks++;
      if (bus.rsp_valid[0] !== 1'b1 || rd_of(0) !== 16'h0F0F) begin
         failures++;
         $display("[TB] FAIL stall_wr_hold got valid=%b data=%h exp valid=1 data=0f0f", bus.rsp_valid[0], rd_of(0));
      end
      set_req(0, 1'b1, 1'b0, 2'd3, '0);
      bus.rsp_ready = 2'b11;
      tick();
      checks++;
      if (bus.rsp_valid[0] !== 1'b1 || rd_of(0) !== 16'hBEEF) begin
         failures++;
         $display("[TB] FAIL stall_wr_readback got valid=%b data=%h exp valid=1 data=beef", bus.rsp_valid[0], rd_of(0));
      end
      idle();
      tick();
   endtask

   task automatic test_random();
      logic [1:0]    g;
      logic          we_e;
      logic [IW-1:0] widx_e;
      logic [IW-1:0] ridx_e;
      logic [DW-1:0] wd_e;
      int            gi;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 2; i++) begin
            set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    IW'($urandom_range(0, NR - 1)), DW'($urandom));
         end
         bus.rsp_ready = 2'($urandom_range(0, 3));
         #1;
         g = exp_grant();
         we_e = 1'b0; widx_e = '0; ridx_e = '0; wd_e = '0;
         if (g != 2'b00) begin
            gi = g[1] ? 1 : 0;
            if (bus.req_write[gi]) begin
               we_e = 1'b1; widx_e = idx_of(gi); wd_e = wd_of(gi);
            end else begin
               ridx_e = idx_of(gi);
            end
         end
         checks++; if (bus.req_ready !== g) begin failures++; $display("[TB] FAIL rnd_grant[%0d] got=%b exp=%b", n, bus.req_ready, g); end
         checks++;
         if ({rf_write_enable, rf_write_index, rf_write_data, rf_read_index} !== {we_e, widx_e, wd_e, ridx_e}) begin
            failures++;
            $display("[TB] FAIL rnd_rf_port[%0d] got we=%b widx=%0d wd=%h ridx=%0d exp we=%b widx=%0d wd=%h ridx=%0d",
                     n, rf_write_enable, rf_write_index, rf_write_data, rf_read_index, we_e, widx_e, wd_e, ridx_e);
         end
         tick();
         checks++; if (bus.rsp_valid !== m_rsp_valid) begin failures++; $display("[TB] FAIL rnd_rsp_valid[%0d] got=%b exp=%b", n, bus.rsp_valid, m_rsp_valid); end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rd_of(i) !== m_rsp_data[i]) begin
               failures++;
               $display("[TB] FAIL rnd_rsp_data[%0d][%0d] got=%h exp=%h", n, i, rd_of(i), m_rsp_data[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      idle();
      bus.rsp_ready = 2'b11;
      tick();
      set_req(1, 1'b1, 1'b0, 2'd2, '0);
      bus.rsp_ready = 2'b01;
      tick();
      checks++; if (bus.rsp_valid[1] !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_valid got=%b exp=1", bus.rsp_valid[1]); end
      idle();
      set_req(0, 1'b1, 1'b1, 2'd1, 16'h7777);
      #2;
      checks++; if (bus.req_ready !== 2'b01 || rf_write_enable !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_grant got ready=%b we=%b exp ready=01 we=1", bus.req_ready, rf_write_enable); end
      reset = 1'b0;
      model_reset();
      #1;
      checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("[TB] FAIL mid_rsp_valid got=%b exp=00", bus.rsp_valid); end
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("[TB] FAIL mid_req_ready got=%b exp=00", bus.req_ready); end
      checks++; if (rf_write_enable !== 1'b0) begin failures++; $display("[TB] FAIL mid_we got=%b exp=0", rf_write_enable); end
      @(negedge clk);
      reset = 1'b1;
      idle();
      bus.rsp_ready = 2'b11;
      for (int k = 0; k < NR; k++) begin
         #1;
         checks++;
         if (rf_write_enable !== 1'b1 || rf_write_index !== IW'(k) || rf_write_data !== INIT_VAL) begin
            failures++;
            $display("[TB] FAIL mid_init[%0d] got we=%b idx=%0d data=%h exp we=1 idx=%0d data=%h",
                     k, rf_write_enable, rf_write_index, rf_write_data, k, INIT_VAL);
         end
         tick();
      end
      #1;
      checks++; if (init_done !== 1'b1) begin failures++; $display("[TB] FAIL mid_init_done got=%b exp=1", init_done); end
      set_req(1, 1'b1, 1'b0, 2'd1, '0);
      tick();
      checks++;
      if (bus.rsp_valid[1] !== 1'b1 || rd_of(1) !== INIT_VAL) begin
         failures++;
         $display("[TB] FAIL mid_readback got valid=%b data=%h exp valid=1 data=%h", bus.rsp_valid[1], rd_of(1), INIT_VAL);
      end
      idle();
   endtask

   initial begin
      idle();
      bus.rsp_ready = 2'b11;
      test_reset();
      test_init();
      test_read_after_init();
      test_write_then_read();
      test_alternating();
      test_backpressure();
      test_write_while_stalled();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
Shares the single-read/single-write 4x16 register file between two requesters (e.g. core datapath and debug/loader port) using round-robin arbitration with valid/ready handshakes. After reset it sequences an initialisation pass that writes INIT_VALUE to every register before accepting traffic. Reads return through a registered response channel with per-requester backpressure. Writes are posted and produce no response.

Parameters:
DATA_WIDTH, 16, register data width
INDEX_WIDTH, 2, register index width; NUM_REGS = 2**INDEX_WIDTH
INIT_EN, 1, 1 = run the init write pass after reset; 0 = skip it
INIT_VALUE, 0, value written to every register during init

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted this cycle (combinational grant)
req_write  in  2  1 = write, 0 = read
req_index  in  2*INDEX_WIDTH  requester i at [i*INDEX_WIDTH +: INDEX_WIDTH]
req_wdata  in  2*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  out  2  read response valid
rsp_ready  in  2  read response accepted
rsp_rdata  out  2*DATA_WIDTH  read data, same packing as req_wdata
rf_read_index  out  INDEX_WIDTH  to register file read port
rf_read_data  in  DATA_WIDTH  from register file (combinational read)
rf_write_index  out  INDEX_WIDTH  to register file write port
rf_write_enable  out  1  to register file
rf_write_data  out  DATA_WIDTH  to register file
init_done  out  1  high once the arbiter is in RUN

Behaviour:
- While reset==0: state=INIT, init_cnt=0, rr_ptr=0, rsp_valid=0, rsp_rdata=0, init_done=0. Outputs forced to 0 immediately (async): req_ready, rf_write_enable, rf_write_index, rf_read_index, rf_write_data.
- INIT with INIT_EN=1: each cycle drives rf_write_enable=1, rf_write_index=init_cnt, rf_write_data=INIT_VALUE, and increments init_cnt. After the write to NUM_REGS-1 (NUM_REGS cycles) the block moves to RUN. req_ready=0 throughout.
- INIT with INIT_EN=0: moves to RUN on the first edge after reset release.
- init_done is registered: 1 from the first RUN cycle onward.
- RUN eligibility: elig[i] = req_valid[i] && (req_write[i] || !rsp_valid[i] || rsp_ready[i]).
  - A read from i cannot be granted while i's response is stalled.
  - A write from i can be granted while i's response is stalled.
- RUN grant:
  - Both eligible: grant rr_ptr.
  - One eligible: grant it.
  - After any grant, rr_ptr <= 1 - granted.
  - No grant: rr_ptr holds.
  - req_ready = one-hot grant, at most one bit set.
- Granted write: rf_write_enable=1 with that requester's index and data in the same cycle; the register file updates at that edge.
- Granted read:
  - rf_read_index = requester's index.
  - At the edge: rsp_rdata[i] <= rf_read_data, rsp_valid[i] <= 1.
  - Latency is 1 cycle from accept to rsp_valid.
- Response channel:
  - rsp_valid[i] clears on rsp_valid&&rsp_ready unless a new read for i is granted in the same cycle; in that case it stays 1 with new data.
  - rsp_rdata holds its last value when rsp_valid=0.
- No grant: rf_write_enable=0; rf_read_index, rf_write_index and rf_write_data driven 0.
- Only one register-file operation per cycle, so no same-cycle read/write hazard exists. A read granted the cycle after a write returns the new value.
- Reset asserted mid-operation: pending responses are discarded and in-flight grants are dropped. The init pass reruns after release.

Decomposition:
- Package regfile_pkg holds:
  - DATA_WIDTH and INDEX_WIDTH defaults, and NUM_REGS.
  - State enum arb_state_t {ARB_INIT, ARB_RUN}.
  - The requester count constant (2).
- One sub-module: rr_arbiter2. It contains the combinational grant logic from elig and rr_ptr, plus the rr_ptr register with asynchronous active-low reset.
- Init counter, FSM, response registers and the register-file mux stay in the top module.

Test Plan:
- INIT_VALUE=16'hA5A5, release reset:
  - Expect rf_write_enable=1 with indices 0,1,2,3 on 4 consecutive cycles, req_ready=0, then init_done=1.
  - Requester 0 reads reg 2: rsp_valid[0]=1 one cycle later with rsp_rdata=16'hA5A5.
- Requester 0 writes 16'h1234 to reg 1; next cycle requester 1 reads reg 1 -> rsp_valid[1]=1 next cycle, rsp_rdata[1]=16'h1234.
- Both requesters hold continuous reads from the first RUN cycle, rsp_ready=2'b11 -> req_ready sequence 01,10,01,10, and every rsp_valid rises one cycle after its grant.
- Response backpressure:
  - Requester 0 reads with rsp_ready[0]=0: rsp_valid[0] and its data hold, req_ready[0] stays 0 for further reads, and requester 1 reads are granted every cycle.
  - Raise rsp_ready[0] -> requester 0's pending read is granted that same cycle.
- While rsp_valid[0] is stalled, requester 0 issues a write of 16'hBEEF to reg 3 -> granted and rf_write_enable=1; a later read of reg 3 returns 16'hBEEF.
- Assert reset mid-traffic with rsp_valid[1]=1:
  - rsp_valid, req_ready and rf_write_enable go 0 without waiting for a clock edge.
  - After release the 4-cycle init repeats, and reg 1 reads back INIT_VALUE.
